ext_msg_ram: RTL and testbench
==============================

# ext_msg_ram

Parametrised multi-lane extrinsic message memory for the LDPC decoder. Each word packs `LANES` independent `MSG_WIDTH`-bit messages behind one address, with per-lane write enables so check/variable node units can update individual messages without a read-modify-write. The block also has a built-in clear engine that zeroes the whole array after reset or on request, so a new codeword starts from zero extrinsics. It replaces the fixed 3×6-bit extrinsic RAM and sits between the node processors and the message scheduler.

## Interface
Parameters:
- `MSG_WIDTH`, 6: bits per message lane.
- `LANES`, 3: message lanes per word.
- `ADDR_WIDTH`, 8: address bits.
- `RAM_DEPTH`, `1<<ADDR_WIDTH`: words stored; must be ≤ `1<<ADDR_WIDTH`.

Ports:
- `clk`  in  1: the only clock; everything is sampled on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cs`  in  1: access strobe.
- `we`  in  1: 1 = write, 0 = read; only meaningful when `cs`=1.
- `lane_en`  in  `LANES`: per-lane write enable.
- `address`  in  `ADDR_WIDTH`: word address.
- `data_in`  in  `LANES*MSG_WIDTH`: write data. Lane i occupies `[i*MSG_WIDTH +: MSG_WIDTH]`, and lane 0 is the LSBs.
- `clear_req`  in  1: one-cycle pulse that starts a full-array clear.
- `data_out`  out  `LANES*MSG_WIDTH`: registered read data, same lane packing as `data_in`.
- `rd_valid`  out  1: pulses high for one cycle when `data_out` has been updated by an accepted access.
- `busy`  out  1: clear sweep in progress.

## Operation
- Two states, `IDLE` and `CLEAR`. A sweep counter `clr_addr` is `ADDR_WIDTH` bits wide.
- **Reset.** `rst`=1 forces `CLEAR` with `clr_addr`=0, `busy`=1, `data_out`=0 and `rd_valid`=0. No array writes occur while `rst` is held.
- **CLEAR.** On each edge with `rst`=0, all lanes of `mem[clr_addr]` are written to 0 and `clr_addr` increments. On the edge that writes `RAM_DEPTH-1`, the block goes to `IDLE` and `busy` goes to 0.
- **CLEAR, user inputs.** `cs`, `we`, `lane_en` and `clear_req` are ignored. `data_out` holds its value and `rd_valid` stays 0.
- **IDLE, `clear_req`=1.** The block enters `CLEAR` with `clr_addr`=0 and `busy`=1 on the next edge.
  - If `cs` is also high in that cycle, the access is still performed. Its `rd_valid` pulse coincides with the first `busy` cycle.
- **IDLE, `cs`=1 and `we`=1.**
  - Each lane i with `lane_en[i]`=1 is written with `data_in` lane i. Other lanes keep their stored value.
  - Write-first: on the next cycle `data_out` shows the resulting stored word and `rd_valid`=1.
  - `lane_en`=0 still produces a read of the unchanged word.
- **IDLE, `cs`=1 and `we`=0.** `data_out` = `mem[address]` on the next cycle, with `rd_valid`=1.
- **IDLE, `cs`=0.** `data_out` holds its value and `rd_valid`=0.
- `address` ≥ `RAM_DEPTH` is illegal and the result is undefined. The bench must not drive it.

## Timing
- Read and write latency is 1 cycle. The array is inferred as synchronous single-port RAM, one instance per lane.
- Back-to-back accesses are supported. A read of an address written on the previous edge returns the new data.
- Sweep length, counting from the first edge where `rst` is sampled low:
  - `busy` stays high for exactly `RAM_DEPTH` edges.
  - The first access accepted is on edge `RAM_DEPTH+1`.
  - Reset value of `busy` is 1.
- `rst` asserted mid-sweep restarts the sweep from address 0, and the full `RAM_DEPTH` edges are needed again.
- `rst` and `clear_req` in the same cycle: `rst` wins.
- `clear_req` while `busy`=1 is dropped and is not queued.

## Test plan
Directed scenarios, using default parameters unless stated:
- **Reset sweep.** Hold `rst` 2 cycles, then release. Required: `busy`=1 for exactly 256 edges after release, and then `busy`=0. Then read 0x5A: one cycle later `data_out`=18'h00000 and `rd_valid`=1.
- **Full write/read.** Write 18'h3F0C1 to 0x10 with `lane_en`=3'b111. Required: next cycle `data_out`=18'h3F0C1. A following read of 0x10 returns 18'h3F0C1.
- **Lane mask.** Write `data_in`=18'h00000 to 0x10 with `lane_en`=3'b010. Required: `data_out`=18'h3F001, and later reads of 0x10 return 18'h3F001.
- **Clear blocks access.** In `IDLE`, pulse `clear_req`. Attempt a write of 18'h12345 to 0x20 while `busy`=1. Required: `rd_valid` stays 0. After the sweep, reads of 0x10 and 0x20 both return 0.
- **Reset mid-sweep.** Pulse `rst` for 1 cycle when `clr_addr`=100. Required: `busy` stays high for a further 256 edges after `rst` falls, and a read of 0x05 returns 0.
- **Hold and parameterisation.** With `cs`=0 for 10 cycles, `data_out` stays constant and `rd_valid`=0. Rerun the lane-mask scenario with `LANES`=4, `MSG_WIDTH`=8 and `ADDR_WIDTH`=6: the sweep takes 64 edges, and masked writes behave the same way.

Source files
------------

// File: rtl/ext_msg_ram_if.sv
// ext_msg_ram_if
// Bus bundle between the extrinsic message RAM and its users (node
// processors / message scheduler).
//   master: drives cs, we, lane_en, address, data_in, clear_req;
//           receives data_out, rd_valid, busy.
//   slave : the RAM side of the same signals.
interface ext_msg_ram_if #(
  parameter int MSG_WIDTH  = 6,
  parameter int LANES      = 3,
  parameter int ADDR_WIDTH = 8
) ();

  logic                         cs;
  logic                         we;
  logic [LANES-1:0]             lane_en;
  logic [ADDR_WIDTH-1:0]        address;
  logic [LANES*MSG_WIDTH-1:0]   data_in;
  logic                         clear_req;
  logic [LANES*MSG_WIDTH-1:0]   data_out;
  logic                         rd_valid;
  logic                         busy;

  modport master (
    output cs, we, lane_en, address, data_in, clear_req,
    input  data_out, rd_valid, busy
  );

  modport slave (
    input  cs, we, lane_en, address, data_in, clear_req,
    output data_out, rd_valid, busy
  );

endinterface

// File: rtl/ext_msg_ram.sv
// ext_msg_ram
// Multi-lane extrinsic message memory. Each word holds LANES messages of
// MSG_WIDTH bits, lane 0 in the LSBs. Lanes are written independently via
// lane_en, and a clear engine zeroes the whole array after reset or on
// clear_req so every codeword starts from zero extrinsics.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (restarts the clear sweep)
//   bus  - ext_msg_ram_if.slave: cs/we/lane_en/address/data_in/clear_req in,
//          data_out (registered, write-first), rd_valid pulse, busy out
module ext_msg_ram #(
  parameter int MSG_WIDTH  = 6,
  parameter int LANES      = 3,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  ext_msg_ram_if.slave  bus
);

  localparam int WORD_W = LANES * MSG_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  clr_addr_q, clr_addr_d;
  logic                   busy_q, busy_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [WORD_W-1:0]      data_out_q, data_out_d;

  logic                   acc_s;       // user access accepted this cycle
  logic                   clr_wr_s;    // sweep write this cycle
  logic [ADDR_WIDTH-1:0]  ram_addr_s;
  logic [LANES-1:0]       lane_we_s;
  logic [WORD_W-1:0]      ram_rdata_s;

  // Next-state logic: clear sweep sequencing and access acceptance
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    busy_d     = busy_q;
    rd_valid_d = 1'b0;
    acc_s      = 1'b0;
    clr_wr_s   = 1'b0;
    case (state_q)
      CLEAR: begin
        // User inputs are ignored for the whole sweep.
        clr_wr_s = 1'b1;
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = IDLE;
          clr_addr_d = ADDR_ZERO;
          busy_d     = 1'b0;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_ONE;
          busy_d     = 1'b1;
        end
      end
      IDLE: begin
        // An access coinciding with clear_req is still carried out; its
        // rd_valid lands on the first busy cycle.
        if (bus.cs) begin
          acc_s      = 1'b1;
          rd_valid_d = 1'b1;
        end else begin
          acc_s      = 1'b0;
        end
        if (bus.clear_req) begin
          state_d    = CLEAR;
          clr_addr_d = ADDR_ZERO;
          busy_d     = 1'b1;
        end else begin
          busy_d     = 1'b0;
        end
      end
      default: begin
        state_d    = CLEAR;
        clr_addr_d = ADDR_ZERO;
        busy_d     = 1'b1;
      end
    endcase
  end

  // Array port control: sweep owns the port while clearing, no writes in reset
  always_comb begin
    ram_addr_s = bus.address;
    lane_we_s  = {LANES{1'b0}};
    if (rst) begin
      lane_we_s = {LANES{1'b0}};
    end else if (clr_wr_s) begin
      ram_addr_s = clr_addr_q;
      lane_we_s  = {LANES{1'b1}};
    end else if (acc_s && bus.we) begin
      lane_we_s  = bus.lane_en;
    end else begin
      lane_we_s  = {LANES{1'b0}};
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [MSG_WIDTH-1:0] mem [RAM_DEPTH];
    logic [MSG_WIDTH-1:0] wdata_s;

    assign wdata_s = clr_wr_s ? {MSG_WIDTH{1'b0}}
                              : bus.data_in[g*MSG_WIDTH +: MSG_WIDTH];

    // Per-lane array write port
    always_ff @(posedge clk) begin
      if (lane_we_s[g]) begin
        mem[ram_addr_s] <= wdata_s;
      end
    end

    assign ram_rdata_s[g*MSG_WIDTH +: MSG_WIDTH] = mem[bus.address];
  end

  // Read data: write-first per lane, otherwise the stored word; hold when idle
  always_comb begin
    data_out_d = data_out_q;
    if (acc_s) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.we && bus.lane_en[i]) begin
          data_out_d[i*MSG_WIDTH +: MSG_WIDTH] = bus.data_in[i*MSG_WIDTH +: MSG_WIDTH];
        end else begin
          data_out_d[i*MSG_WIDTH +: MSG_WIDTH] = ram_rdata_s[i*MSG_WIDTH +: MSG_WIDTH];
        end
      end
    end else begin
      data_out_d = data_out_q;
    end
  end

  // State and output registers; reset restarts the sweep from address 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= ADDR_ZERO;
      busy_q     <= 1'b1;
      rd_valid_q <= 1'b0;
      data_out_q <= {WORD_W{1'b0}};
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      data_out_q <= data_out_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_ext_msg_ram.sv
// tb_ext_msg_ram
// Directed, table-driven bench for ext_msg_ram. Instance u_dut0 uses the
// default 3x6-bit / 256-word configuration, u_dut1 a 4x8-bit / 64-word one.
module tb_ext_msg_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1;
  logic rst1 = 1'b1;

  ext_msg_ram_if #(.MSG_WIDTH(6), .LANES(3), .ADDR_WIDTH(8)) bus0 ();
  ext_msg_ram_if #(.MSG_WIDTH(8), .LANES(4), .ADDR_WIDTH(6)) bus1 ();

  ext_msg_ram #(.MSG_WIDTH(6), .LANES(3), .ADDR_WIDTH(8), .RAM_DEPTH(256)) u_dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0.slave)
  );

  ext_msg_ram #(.MSG_WIDTH(8), .LANES(4), .ADDR_WIDTH(6), .RAM_DEPTH(64)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1.slave)
  );

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic        cs;
    logic        we;
    logic [2:0]  en;
    logic [7:0]  addr;
    logic [17:0] din;
    logic [17:0] exp_dout;
    logic        exp_valid;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic drive0(input logic cs, input logic we, input logic [2:0] en,
                        input logic [7:0] addr, input logic [17:0] din, input logic clr);
    @(negedge clk);
    bus0.cs        = cs;
    bus0.we        = we;
    bus0.lane_en   = en;
    bus0.address   = addr;
    bus0.data_in   = din;
    bus0.clear_req = clr;
  endtask

  task automatic acc0(input string name, input logic cs, input logic we, input logic [2:0] en,
                      input logic [7:0] addr, input logic [17:0] din,
                      input logic [17:0] exp_dout, input logic exp_valid);
    drive0(cs, we, en, addr, din, 1'b0);
    @(posedge clk);
    #1;
    check({name, "_dout"},  32'(bus0.data_out), 32'(exp_dout));
    check({name, "_valid"}, 32'(bus0.rd_valid), 32'(exp_valid));
    bus0.cs = 1'b0;
  endtask

  task automatic acc1(input string name, input logic we, input logic [3:0] en,
                      input logic [5:0] addr, input logic [31:0] din, input logic [31:0] exp_dout);
    @(negedge clk);
    bus1.cs      = 1'b1;
    bus1.we      = we;
    bus1.lane_en = en;
    bus1.address = addr;
    bus1.data_in = din;
    @(posedge clk);
    #1;
    check({name, "_dout"},  bus1.data_out, exp_dout);
    check({name, "_valid"}, 32'(bus1.rd_valid), 32'd1);
    bus1.cs = 1'b0;
  endtask

  // Counts edges until busy drops (bounded); returns the bound on timeout.
  task automatic count_busy0(output int n);
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (!bus0.busy) break;
    end
  endtask

  task automatic count_busy1(output int n);
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (!bus1.busy) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    logic [17:0] held;

    bus0.cs = 1'b0; bus0.we = 1'b0; bus0.lane_en = 3'b000; bus0.address = 8'h00;
    bus0.data_in = 18'h00000; bus0.clear_req = 1'b0;
    bus1.cs = 1'b0; bus1.we = 1'b0; bus1.lane_en = 4'b0000; bus1.address = 6'h00;
    bus1.data_in = 32'h0; bus1.clear_req = 1'b0;

    vecs[0]  = '{"rd_5A_zero",    1'b1, 1'b0, 3'b000, 8'h5A, 18'h00000, 18'h00000, 1'b1};
    vecs[1]  = '{"wr_10_full",    1'b1, 1'b1, 3'b111, 8'h10, 18'h3F0C1, 18'h3F0C1, 1'b1};
    vecs[2]  = '{"rd_10_full",    1'b1, 1'b0, 3'b000, 8'h10, 18'h00000, 18'h3F0C1, 1'b1};
    vecs[3]  = '{"wr_10_mask010", 1'b1, 1'b1, 3'b010, 8'h10, 18'h00000, 18'h3F001, 1'b1};
    vecs[4]  = '{"rd_10_masked",  1'b1, 1'b0, 3'b000, 8'h10, 18'h00000, 18'h3F001, 1'b1};
    vecs[5]  = '{"idle_hold",     1'b0, 1'b0, 3'b111, 8'h10, 18'h15555, 18'h3F001, 1'b0};
    vecs[6]  = '{"wr_10_noen",    1'b1, 1'b1, 3'b000, 8'h10, 18'h3FFFF, 18'h3F001, 1'b1};
    vecs[7]  = '{"wr_20_mask101", 1'b1, 1'b1, 3'b101, 8'h20, 18'h12345, 18'h12005, 1'b1};
    vecs[8]  = '{"rd_20",         1'b1, 1'b0, 3'b000, 8'h20, 18'h00000, 18'h12005, 1'b1};
    vecs[9]  = '{"wr_21_full",    1'b1, 1'b1, 3'b111, 8'h21, 18'h2AAAA, 18'h2AAAA, 1'b1};
    vecs[10] = '{"rd_20_again",   1'b1, 1'b0, 3'b000, 8'h20, 18'h00000, 18'h12005, 1'b1};
    vecs[11] = '{"rd_21",         1'b1, 1'b0, 3'b000, 8'h21, 18'h00000, 18'h2AAAA, 1'b1};

    // Reset sweep: reset values, then 256 busy edges after release.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  32'(bus0.busy), 32'd1);
    check("rst_dout",  32'(bus0.data_out), 32'd0);
    check("rst_valid", 32'(bus0.rd_valid), 32'd0);
    @(negedge clk);
    rst0 = 1'b0;
    count_busy0(n);
    check("rst_sweep_len", n, 32'd256);

    // Table-driven accesses in IDLE.
    for (int i = 0; i < 12; i++) begin
      acc0(vecs[i].name, vecs[i].cs, vecs[i].we, vecs[i].en, vecs[i].addr,
           vecs[i].din, vecs[i].exp_dout, vecs[i].exp_valid);
    end

    // Ten idle cycles: data_out holds, no valid.
    bad = 0;
    drive0(1'b0, 1'b1, 3'b111, 8'h21, 18'h3FFFF, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (bus0.data_out !== 18'h2AAAA || bus0.rd_valid !== 1'b0) bad++;
    end
    check("hold_10_cycles", bad, 32'd0);

    // clear_req together with a read of 0x10: read still completes.
    drive0(1'b1, 1'b0, 3'b000, 8'h10, 18'h00000, 1'b1);
    @(posedge clk);
    #1;
    check("clr_coinc_busy",  32'(bus0.busy), 32'd1);
    check("clr_coinc_valid", 32'(bus0.rd_valid), 32'd1);
    check("clr_coinc_dout",  32'(bus0.data_out), 32'h3F001);

    // Write held during the sweep is ignored; a clear_req mid-sweep is dropped.
    drive0(1'b1, 1'b1, 3'b111, 8'h20, 18'h12345, 1'b0);
    bad = 0;
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus0.rd_valid !== 1'b0 || bus0.data_out !== 18'h3F001) bad++;
      bus0.clear_req = (n == 10);
      if (!bus0.busy) break;
    end
    bus0.cs = 1'b0;
    bus0.clear_req = 1'b0;
    check("clr_blocks_access", bad, 32'd0);
    check("clr_sweep_len", n, 32'd256);
    @(posedge clk);
    #1;
    check("clr_req_not_queued", 32'(bus0.busy), 32'd0);
    acc0("clr_rd_10", 1'b1, 1'b0, 3'b000, 8'h10, 18'h00000, 18'h00000, 1'b1);
    acc0("clr_rd_20", 1'b1, 1'b0, 3'b000, 8'h20, 18'h00000, 18'h00000, 1'b1);

    // Reset mid-sweep (clr_addr = 100) restarts the full sweep.
    acc0("wr_F0", 1'b1, 1'b1, 3'b111, 8'hF0, 18'h3F3F3, 18'h3F3F3, 1'b1);
    acc0("wr_05", 1'b1, 1'b1, 3'b111, 8'h05, 18'h0ABCD, 18'h0ABCD, 1'b1);
    drive0(1'b0, 1'b0, 3'b000, 8'h00, 18'h00000, 1'b1);
    @(posedge clk);
    #1;
    check("mid_clr_start_busy", 32'(bus0.busy), 32'd1);
    @(negedge clk);
    bus0.clear_req = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy",  32'(bus0.busy), 32'd1);
    check("mid_rst_dout",  32'(bus0.data_out), 32'd0);
    @(negedge clk);
    rst0 = 1'b0;
    count_busy0(n);
    check("mid_rst_sweep_len", n, 32'd256);
    acc0("mid_rd_05", 1'b1, 1'b0, 3'b000, 8'h05, 18'h00000, 18'h00000, 1'b1);
    acc0("mid_rd_F0", 1'b1, 1'b0, 3'b000, 8'hF0, 18'h00000, 18'h00000, 1'b1);

    // Idle hold with a non-zero value on the port.
    acc0("hold_prep", 1'b1, 1'b1, 3'b111, 8'h33, 18'h2468A, 18'h2468A, 1'b1);
    held = 18'h2468A;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (bus0.data_out !== held || bus0.rd_valid !== 1'b0) bad++;
    end
    check("hold_nonzero", bad, 32'd0);

    // Second configuration: 4 lanes x 8 bits, 64 words.
    @(negedge clk);
    rst1 = 1'b0;
    count_busy1(n);
    check("p_sweep_len", n, 32'd64);
    acc1("p_rd_0A",      1'b0, 4'b0000, 6'h0A, 32'h00000000, 32'h00000000);
    acc1("p_wr_full",    1'b1, 4'b1111, 6'h10, 32'hA1B2C3D4, 32'hA1B2C3D4);
    acc1("p_wr_m0010",   1'b1, 4'b0010, 6'h10, 32'h00000000, 32'hA1B200D4);
    acc1("p_rd_m0010",   1'b0, 4'b0000, 6'h10, 32'h00000000, 32'hA1B200D4);
    acc1("p_wr_m1001",   1'b1, 4'b1001, 6'h10, 32'h11223344, 32'h11B20044);
    acc1("p_rd_m1001",   1'b0, 4'b0000, 6'h10, 32'h00000000, 32'h11B20044);
    acc1("p_rd_3F",      1'b0, 4'b0000, 6'h3F, 32'h00000000, 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
